// File: rtl/dmem_dma.sv
// dmem_dma: block copy through the single-ported data memory. Each word takes one read cycle and then one write cycle.
// Fill mode (constant pattern, one write per cycle) is built only when DMEM_DMA_FILL_EN is defined.
module dmem_dma #(
   parameter int LEN_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             fill,
   input  logic [31:0]      src,
   input  logic [31:0]      dst,
   input  logic [LEN_W-1:0] len,
   input  logic [31:0]      pattern,
   output logic             busy,
   output logic             done,
   output logic [LEN_W-1:0] count,
   output logic             mem_we,
   output logic [31:0]      mem_a,
   output logic [31:0]      mem_wd,
   input  logic [31:0]      mem_rd
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      WRITE = 3'd2,
`ifdef DMEM_DMA_FILL_EN
      FILL  = 3'd3,
`endif
      DONE  = 3'd4
   } state_t;

   state_t           state;
   logic [29:0]      sptr;
   logic [29:0]      dptr;
   logic [LEN_W-1:0] len_q;
   logic             last;

   assign last = (count + LEN_W'(1)) == len_q;

`ifdef DMEM_DMA_FILL_EN
   logic unused_bits;
   assign unused_bits = ^{src[1:0], dst[1:0]};
`else
   logic unused_bits;
   assign unused_bits = ^{src[1:0], dst[1:0], fill, pattern};
`endif

   // mem_wd doubles as the read buffer, and in fill mode it holds the pattern.
   // The memory pins are registered and are loaded one state ahead of their use.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         sptr   <= '0;
         dptr   <= '0;
         len_q  <= '0;
         count  <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         mem_we <= 1'b0;
         mem_a  <= '0;
         mem_wd <= '0;
      end else begin
         case (state)
            IDLE: begin
               done   <= 1'b0;
               busy   <= 1'b0;
               mem_we <= 1'b0;
               if (start) begin
                  sptr  <= src[31:2];
                  dptr  <= dst[31:2];
                  len_q <= len;
                  count <= '0;
                  if (len == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
`ifdef DMEM_DMA_FILL_EN
                  else if (fill) begin
                     state  <= FILL;
                     busy   <= 1'b1;
                     mem_we <= 1'b1;
                     mem_a  <= {dst[31:2], 2'b00};
                     mem_wd <= pattern;
                  end
`endif
                  else begin
                     state <= READ;
                     busy  <= 1'b1;
                     mem_a <= {src[31:2], 2'b00};
                  end
               end
            end
            READ: begin
               state  <= WRITE;
               mem_wd <= mem_rd;
               mem_we <= 1'b1;
               mem_a  <= {dptr, 2'b00};
            end
            WRITE: begin
               count  <= count + LEN_W'(1);
               sptr   <= sptr + 30'd1;
               dptr   <= dptr + 30'd1;
               mem_we <= 1'b0;
               mem_wd <= '0;
               if (last) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  mem_a <= '0;
               end else begin
                  state <= READ;
                  mem_a <= {sptr + 30'd1, 2'b00};
               end
            end
`ifdef DMEM_DMA_FILL_EN
            FILL: begin
               count <= count + LEN_W'(1);
               dptr  <= dptr + 30'd1;
               if (last) begin
                  state  <= DONE;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  mem_we <= 1'b0;
                  mem_a  <= '0;
                  mem_wd <= '0;
               end else begin
                  mem_a <= {dptr + 30'd1, 2'b00};
               end
            end
`endif
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               busy   <= 1'b0;
               done   <= 1'b0;
               mem_we <= 1'b0;
               mem_a  <= '0;
               mem_wd <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_dma.sv
// tb_dmem_dma: directed and random transfers against a word-array reference model and a cycle-timing model.
module tb_dmem_dma;

`ifdef DMEM_DMA_FILL_EN
   localparam bit FILL_BUILT = 1'b1;
`else
   localparam bit FILL_BUILT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        fill = 1'b0;
   logic [31:0] src = '0;
   logic [31:0] dst = '0;
   logic [15:0] len = '0;
   logic [31:0] pattern = '0;
   logic        busy, done, mem_we;
   logic [15:0] count;
   logic [31:0] mem_a, mem_wd, mem_rd;

   logic [31:0] mem  [256];
   logic [31:0] refm [256];
   logic        ld_en = 1'b0;
   logic [7:0]  ld_a = '0;
   logic [31:0] ld_d = '0;

   int vectors = 0;
   int errors  = 0;

   dmem_dma dut (
      .clk(clk), .reset(reset), .start(start), .fill(fill),
      .src(src), .dst(dst), .len(len), .pattern(pattern),
      .busy(busy), .done(done), .count(count),
      .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
   );

   always #5 clk = ~clk;

   // 1 KB memory that wraps on the word address.
   assign mem_rd = mem[mem_a[9:2]];
   always @(posedge clk) begin
      if (ld_en)       mem[ld_a] <= ld_d;
      else if (mem_we) mem[mem_a[9:2]] <= mem_wd;
   end

   function automatic int idx(input logic [31:0] a);
      return int'(a[9:2]);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic poke(input logic [7:0] a, input logic [31:0] d);
      @(negedge clk);
      ld_en = 1'b1; ld_a = a; ld_d = d;
      @(posedge clk);
      #1 ld_en = 1'b0;
      refm[a] = d;
   endtask

   // While the block is busy or in DONE, keep requesting with fresh junk.
   task automatic noise();
      start   = 1'b1;
      src     = $urandom;
      dst     = $urandom;
      len     = 16'($urandom);
      fill    = 1'($urandom);
      pattern = $urandom;
   endtask

   task automatic check_idle_zero(input string tag);
      chk({tag, "_busy"},  32'(busy),   32'd0);
      chk({tag, "_done"},  32'(done),   32'd0);
      chk({tag, "_count"}, 32'(count),  32'd0);
      chk({tag, "_we"},    32'(mem_we), 32'd0);
      chk({tag, "_a"},     mem_a,       32'd0);
      chk({tag, "_wd"},    mem_wd,      32'd0);
   endtask

   task automatic cmp_mem();
      for (int i = 0; i < 256; i++) chk("mem_word", mem[i], refm[i]);
   endtask

   // Run one transfer. abort_c != 0 asserts reset in that cycle, before its closing edge.
   task automatic run(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                      input logic f, input logic [31:0] p, input int abort_c);
      bit          fm;
      bit          aborted;
      int          last;
      int          k;
      logic [31:0] sa, da, v, off;
      fm      = f && FILL_BUILT;
      aborted = 1'b0;
      sa      = s & 32'hFFFF_FFFC;
      da      = d & 32'hFFFF_FFFC;
      v       = '0;
      last    = (n == 0) ? 1 : (fm ? int'(n) + 1 : 2 * int'(n) + 1);
      @(negedge clk);
      start = 1'b1; src = s; dst = d; len = n; fill = f; pattern = p;
      @(posedge clk);
      for (int c = 1; c <= last && !aborted; c++) begin
         @(negedge clk);
         if (c == last) begin
            chk("done_hi",   32'(done),   32'd1);
            chk("done_busy", 32'(busy),   32'd0);
            chk("done_we",   32'(mem_we), 32'd0);
            chk("done_cnt",  32'(count),  32'(n));
         end else begin
            chk("busy", 32'(busy), 32'd1);
            chk("done_lo", 32'(done), 32'd0);
            if (fm) begin
               k   = c - 1;
               off = 32'(4 * k);
               chk("fill_we",  32'(mem_we), 32'd1);
               chk("fill_a",   mem_a,       da + off);
               chk("fill_wd",  mem_wd,      p);
               chk("fill_cnt", 32'(count),  32'(k));
               if (c != abort_c) refm[idx(da + off)] = p;
            end else begin
               k   = (c - 1) / 2;
               off = 32'(4 * k);
               if (c % 2 == 1) begin
                  chk("rd_we",  32'(mem_we), 32'd0);
                  chk("rd_a",   mem_a,       sa + off);
                  chk("rd_cnt", 32'(count),  32'(k));
                  v = refm[idx(sa + off)];
               end else begin
                  chk("wr_we",  32'(mem_we), 32'd1);
                  chk("wr_a",   mem_a,       da + off);
                  chk("wr_wd",  mem_wd,      v);
                  chk("wr_cnt", 32'(count),  32'(k));
                  if (c != abort_c) refm[idx(da + off)] = v;
               end
            end
         end
         if (c == abort_c) begin
            reset = 1'b1;
            start = 1'b0;
            #1;
            check_idle_zero("abort");
            @(posedge clk);
            @(negedge clk);
            reset   = 1'b0;
            aborted = 1'b1;
         end else begin
            noise();
         end
      end
      if (!aborted) begin
         @(negedge clk);
         start = 1'b0;
         chk("idle_done", 32'(done),   32'd0);
         chk("idle_busy", 32'(busy),   32'd0);
         chk("idle_we",   32'(mem_we), 32'd0);
         chk("hold_cnt",  32'(count),  32'(n));
      end
      cmp_mem();
   endtask

   initial begin
      #3;
      check_idle_zero("reset");
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 256; i++) poke(8'(i), $urandom);

      // 4-word copy 0x00 -> 0x40
      poke(8'd0, 32'h11); poke(8'd1, 32'h22); poke(8'd2, 32'h33); poke(8'd3, 32'h44);
      run(32'h0, 32'h40, 16'd4, 1'b0, 32'h0, 0);
      chk("copy_w0", mem[16], 32'h11);
      chk("copy_w3", mem[19], 32'h44);

      // zero length
      run(32'h0000_0120, 32'h0000_0200, 16'd0, 1'b0, 32'h0, 0);

      // fill request (behaves as a copy when fill mode is not built)
      run(32'h100, 32'h80, 16'd3, 1'b1, 32'hDEAD_BEEF, 0);

      // overlapping forward copy smears word 0
      poke(8'd0, 32'hA);
      run(32'h0, 32'h4, 16'd3, 1'b0, 32'h0, 0);
      chk("ovl_w3", mem[3], 32'hA);

      // unaligned addresses
      run(32'h3, 32'h22, 16'd2, 1'b0, 32'h0, 0);

      // address wrap-around past 2^32
      run(32'hFFFF_FFF8, 32'h10, 16'd4, 1'b0, 32'h0, 0);

      // reset during the write of word 1, then a normal transfer
      run(32'h200, 32'h300, 16'd4, 1'b0, 32'h0, 4);
      run(32'h200, 32'h300, 16'd4, 1'b0, 32'h0, 0);

      for (int r = 0; r < 25; r++)
         run($urandom, $urandom, 16'($urandom_range(0, 8)), 1'($urandom), $urandom, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
